vx_rr_find_first: RTL and testbench

//  Registered, handshaked find-first selector: picks one valid lane out of N, forwards its

---
 rtl/vx_rr_find_first.sv | 107 ++++++++++
 tb/tb_vx_rr_find_first.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_rr_find_first.sv
// vx_rr_find_first
//   Registered, handshaked find-first selector. Picks one valid lane out of N and
//   forwards its data and lane index through a single output register stage.
//   Fixed-priority mode searches from lane 0 (or lane N-1 with REVERSE). Round-robin
//   mode starts the search at a pointer that rotates past the last winner.
//
// Ports
//   clk      clock
//   reset    synchronous, active-high reset
//   valid_i  per-lane request valid
//   data_i   per-lane data, lane i at [i*DATAW +: DATAW]
//   ready_i  per-lane accept, one-hot or zero
//   valid_o  output register holds a selected item
//   data_o   selected lane data
//   index_o  selected lane number
//   ready_o  downstream accept
module vx_rr_find_first #(
    parameter int unsigned N       = 4,
    parameter int unsigned DATAW   = 8,
    parameter bit          REVERSE = 1'b0,
    parameter bit          RR      = 1'b1,
    parameter int unsigned LOGN    = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       valid_i,
    input  logic [N*DATAW-1:0] data_i,
    output logic [N-1:0]       ready_i,
    output logic               valid_o,
    output logic [DATAW-1:0]   data_o,
    output logic [LOGN-1:0]    index_o,
    input  logic               ready_o
);

    localparam logic [LOGN-1:0] LAST  = LOGN'(N - 1);
    localparam logic [LOGN-1:0] FIRST = REVERSE ? LAST : '0;

    logic [LOGN-1:0] ptr_q, ptr_d;
    logic [LOGN-1:0] start;
    logic [LOGN-1:0] win;
    logic [LOGN-1:0] idx;
    logic            any;
    logic            advance;
    logic [DATAW-1:0] win_data;

    assign advance = !valid_o || ready_o;
    assign start   = RR ? ptr_q : FIRST;

    // Walk the lanes from the start point with explicit wrap at 0 / N-1 so a
    // non-power-of-two N never visits an out-of-range lane.
    always_comb begin
        idx = start;
        win = '0;
        any = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any && valid_i[idx]) begin
                any = 1'b1;
                win = idx;
            end
            if (REVERSE) begin
                idx = (idx == '0) ? LAST : idx - 1'b1;
            end else begin
                idx = (idx == LAST) ? '0 : idx + 1'b1;
            end
        end
    end

    always_comb begin
        win_data = data_i[int'(win)*DATAW +: DATAW];
    end

    // Next start point sits one step past the winner in search direction.
    always_comb begin
        if (REVERSE) begin
            ptr_d = (win == '0) ? LAST : win - 1'b1;
        end else begin
            ptr_d = (win == LAST) ? '0 : win + 1'b1;
        end
    end

    // Grant only when the output register can take the item this edge.
    always_comb begin
        ready_i = '0;
        if (!reset && advance && any) begin
            ready_i[win] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_o <= 1'b0;
            data_o  <= '0;
            index_o <= '0;
            ptr_q   <= FIRST;
        end else if (advance) begin
            valid_o <= any;
            if (any) begin
                data_o  <= win_data;
                index_o <= win;
                if (RR) begin
                    ptr_q <= ptr_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_vx_rr_find_first.sv
// tb_vx_rr_find_first
//   Six configurations of vx_rr_find_first share a clock and reset: RR/fixed,
//   ascending/descending, N=4, N=5 and N=1. Directed steps followed by random
//   traffic, all compared against a modular-arithmetic reference model.
module tb_vx_rr_find_first;

    localparam int NCFG = 6;

    function automatic int cfg_n(int g);
        case (g)
            3:       return 5;
            5:       return 1;
            default: return 4;
        endcase
    endfunction

    function automatic bit cfg_rr(int g);
        return (g == 0) || (g == 2) || (g == 3) || (g == 5);
    endfunction

    function automatic bit cfg_rev(int g);
        return (g == 2) || (g == 4);
    endfunction

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  vin  [NCFG];
    logic [39:0] din  [NCFG];
    logic        rout [NCFG];
    logic        vo   [NCFG];
    logic [7:0]  dout [NCFG];
    logic [4:0]  rin  [NCFG];
    logic [2:0]  iout [NCFG];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        localparam int unsigned NN = cfg_n(g);
        localparam int unsigned LG = (NN > 1) ? $clog2(NN) : 1;
        logic [LG-1:0] idx;
        logic [NN-1:0] rdyi;
        vx_rr_find_first #(
            .N      (NN),
            .DATAW  (8),
            .REVERSE(cfg_rev(g)),
            .RR     (cfg_rr(g)),
            .LOGN   (LG)
        ) u_dut (
            .clk    (clk),
            .reset  (reset),
            .valid_i(vin[g][NN-1:0]),
            .data_i (din[g][NN*8-1:0]),
            .ready_i(rdyi),
            .valid_o(vo[g]),
            .data_o (dout[g]),
            .index_o(idx),
            .ready_o(rout[g])
        );
        assign rin[g]  = 5'(rdyi);
        assign iout[g] = 3'(idx);
    end

    int errors = 0;
    int checks = 0;

    // Reference state: what the output register and start pointer should hold.
    int         m_ptr [NCFG];
    bit         m_vo  [NCFG];
    logic [7:0] m_do  [NCFG];
    int         m_io  [NCFG];

    task automatic chk(string tag, logic [39:0] obs, logic [39:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // First lane with valid set, visiting start, start+1, ... mod n (or downward).
    function automatic int find_w(logic [4:0] v, int start, int n, bit rev);
        for (int k = 0; k < n; k++) begin
            int lane;
            lane = rev ? (start - k + n) % n : (start + k) % n;
            if (v[lane]) return lane;
        end
        return -1;
    endfunction

    task automatic drive(logic [4:0] v, bit r);
        for (int g = 0; g < NCFG; g++) begin
            vin[g]  = v;
            rout[g] = r;
            din[g]  = {8'($urandom), $urandom};
        end
    endtask

    task automatic cycle();
        bit         adv [NCFG];
        int         ws  [NCFG];
        logic [7:0] wd  [NCFG];
        #1;
        for (int g = 0; g < NCFG; g++) begin
            int n, st;
            logic [4:0] er;
            n      = cfg_n(g);
            adv[g] = !m_vo[g] || rout[g];
            st     = cfg_rr(g) ? m_ptr[g] : (cfg_rev(g) ? n - 1 : 0);
            ws[g]  = find_w(vin[g] & 5'((1 << n) - 1), st, n, cfg_rev(g));
            wd[g]  = (ws[g] >= 0) ? din[g][ws[g]*8 +: 8] : 8'h0;
            er     = (!reset && adv[g] && ws[g] >= 0) ? 5'(1 << ws[g]) : 5'b0;
            chk($sformatf("ready_i cfg%0d", g), 40'(rin[g]), 40'(er));
        end
        @(posedge clk);
        for (int g = 0; g < NCFG; g++) begin
            int n;
            n = cfg_n(g);
            if (reset) begin
                m_vo[g]  = 1'b0;
                m_do[g]  = 8'h0;
                m_io[g]  = 0;
                m_ptr[g] = cfg_rev(g) ? n - 1 : 0;
            end else if (adv[g]) begin
                m_vo[g] = (ws[g] >= 0);
                if (ws[g] >= 0) begin
                    m_do[g] = wd[g];
                    m_io[g] = ws[g];
                    if (cfg_rr(g)) m_ptr[g] = cfg_rev(g) ? (ws[g] - 1 + n) % n : (ws[g] + 1) % n;
                end
            end
        end
        #1;
        for (int g = 0; g < NCFG; g++) begin
            chk($sformatf("valid_o cfg%0d", g), 40'(vo[g]), 40'(m_vo[g]));
            chk($sformatf("index_o cfg%0d", g), 40'(iout[g]), 40'(m_io[g]));
            chk($sformatf("data_o cfg%0d", g), 40'(dout[g]), 40'(m_do[g]));
        end
    endtask

    initial begin
        int         exp0 [5];
        int         exp2 [5];
        int         exp3 [4];
        logic [7:0] held;

        for (int g = 0; g < NCFG; g++) begin
            m_vo[g]  = 1'b0;
            m_do[g]  = 8'h0;
            m_io[g]  = 0;
            m_ptr[g] = 0;
        end

        // Reset held two cycles with every lane requesting.
        reset = 1'b1;
        drive(5'b11111, 1'b1);
        cycle();
        cycle();
        chk("reset ready_i", 40'(rin[0]), 40'h0);
        chk("reset valid_o", 40'(vo[0]), 40'h0);
        chk("reset index_o", 40'(iout[0]), 40'h0);
        reset = 1'b0;

        // Fixed priority, ascending and descending.
        drive(5'b01010, 1'b1);
        repeat (4) begin
            cycle();
            chk("fixed asc index", 40'(iout[1]), 40'd1);
            chk("fixed asc ready", 40'(rin[1]), 40'b00010);
            chk("fixed desc index", 40'(iout[4]), 40'd3);
            chk("fixed desc ready", 40'(rin[4]), 40'b01000);
        end

        // Round-robin rotation from a fresh pointer.
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        drive(5'b11111, 1'b1);
        exp0 = '{0, 1, 2, 3, 0};
        exp2 = '{3, 2, 1, 0, 3};
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk($sformatf("rr asc step%0d", i), 40'(iout[0]), 40'(exp0[i]));
            chk($sformatf("rr desc step%0d", i), 40'(iout[2]), 40'(exp2[i]));
        end

        // Backpressure: item at lane 2 held while ready_o is low.
        drive(5'b00100, 1'b1);
        cycle();
        chk("bp load index", 40'(iout[0]), 40'd2);
        held = dout[0];
        repeat (3) begin
            drive(5'($urandom), 1'b0);
            cycle();
            chk("bp hold index", 40'(iout[0]), 40'd2);
            chk("bp hold data", 40'(dout[0]), 40'(held));
            chk("bp hold ready", 40'(rin[0]), 40'h0);
        end
        // Pointer is still one past lane 2, so lane 3 beats lane 0.
        drive(5'b01001, 1'b1);
        cycle();
        chk("bp release index", 40'(iout[0]), 40'd3);
        chk("bp release valid", 40'(vo[0]), 40'd1);

        // Non-power-of-two wrap on the N=5 instance.
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        drive(5'b01000, 1'b1);
        cycle();
        drive(5'b10001, 1'b1);
        exp3 = '{4, 0, 4, 0};
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk($sformatf("wrap5 step%0d", i), 40'(iout[3]), 40'(exp3[i]));
        end

        // Idle gap, then reset while a held item is stalled.
        drive(5'b00000, 1'b1);
        cycle();
        chk("idle valid_o", 40'(vo[0]), 40'd0);
        drive(5'b00010, 1'b1);
        cycle();
        drive(5'b00000, 1'b0);
        cycle();
        chk("stall valid_o", 40'(vo[0]), 40'd1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("reset drop asc", 40'(vo[0]), 40'd0);
        chk("reset drop desc", 40'(vo[2]), 40'd0);
        drive(5'b11111, 1'b1);
        cycle();
        chk("ptr after reset asc", 40'(iout[0]), 40'd0);
        chk("ptr after reset desc", 40'(iout[2]), 40'd3);

        // Random traffic with occasional resets and stalls.
        repeat (400) begin
            reset = ($urandom % 64) == 0;
            drive(5'($urandom), ($urandom % 4) != 0);
            cycle();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
